// File: rtl/kgp_isa_pkg.sv
// KGPMini ISA constants shared by the control sequencer and its decoder.
// Opcodes, ALU control codes, sequencer states and instruction classes.
package kgp_isa_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned ALUOP_W  = 3;
  localparam int unsigned ALUSEL_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b000001;
  localparam logic [OP_W-1:0] OP_COMPI = 6'b000010;
  localparam logic [OP_W-1:0] OP_LW    = 6'b000011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b000100;
  localparam logic [OP_W-1:0] OP_BR    = 6'b000101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b000110;
  localparam logic [OP_W-1:0] OP_BZ    = 6'b000111;
  localparam logic [OP_W-1:0] OP_BNZ   = 6'b001000;
  localparam logic [OP_W-1:0] OP_BL    = 6'b001001;
  localparam logic [OP_W-1:0] OP_BCY   = 6'b001010;
  localparam logic [OP_W-1:0] OP_BNCY  = 6'b001011;
  localparam logic [OP_W-1:0] OP_JR    = 6'b001100;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_COMP  = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_PASS  = 3'b011;

  localparam logic [ALUSEL_W-1:0] ALUSEL_RT   = 2'b00;
  localparam logic [ALUSEL_W-1:0] ALUSEL_ZERO = 2'b01;
  localparam logic [ALUSEL_W-1:0] ALUSEL_IMM  = 2'b10;

  localparam int unsigned FLAG_SIGN  = 2;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_CARRY = 0;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LINK, CLS_JR, CLS_HALT, CLS_NOP
  } instr_class_e;

  typedef enum logic [2:0] {
    COND_ALWAYS, COND_SIGN, COND_ZERO, COND_NZERO, COND_CARRY, COND_NCARRY
  } cond_e;

  // Branch-taken test against the {sign, zero, carry} flags.
  function automatic logic cond_met(input cond_e c, input logic [FLAG_W-1:0] f);
    case (c)
      COND_SIGN:   return f[FLAG_SIGN];
      COND_ZERO:   return f[FLAG_ZERO];
      COND_NZERO:  return !f[FLAG_ZERO];
      COND_CARRY:  return f[FLAG_CARRY];
      COND_NCARRY: return !f[FLAG_CARRY];
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/kgp_main_decoder.sv
// Combinational main decoder: latched opcode to instruction class,
// ALU controls and branch-condition select.
module kgp_main_decoder
  import kgp_isa_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  output instr_class_e        cls_c,
  output logic [ALUOP_W-1:0]  alu_op_c,
  output logic [ALUSEL_W-1:0] alu_sel_c,
  output cond_e               cond_c
);

  always_comb begin
    cls_c     = CLS_NOP;
    alu_op_c  = ALUOP_FUNCT;
    alu_sel_c = ALUSEL_RT;
    cond_c    = COND_ALWAYS;
    case (op)
      OP_RTYPE: cls_c = CLS_ALU;
      OP_ADDI: begin
        cls_c     = CLS_ALU;
        alu_op_c  = ALUOP_ADD;
        alu_sel_c = ALUSEL_IMM;
      end
      OP_COMPI: begin
        cls_c     = CLS_ALU;
        alu_op_c  = ALUOP_COMP;
        alu_sel_c = ALUSEL_IMM;
      end
      OP_LW, OP_SW: begin
        cls_c     = (op == OP_LW) ? CLS_LOAD : CLS_STORE;
        alu_op_c  = ALUOP_ADD;
        alu_sel_c = ALUSEL_IMM;
      end
      // Control transfers all pass rs through the ALU (rs + 0).
      OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY: begin
        cls_c     = CLS_BRANCH;
        alu_op_c  = ALUOP_PASS;
        alu_sel_c = ALUSEL_ZERO;
        case (op)
          OP_BLTZ: cond_c = COND_SIGN;
          OP_BZ:   cond_c = COND_ZERO;
          OP_BNZ:  cond_c = COND_NZERO;
          OP_BCY:  cond_c = COND_CARRY;
          OP_BNCY: cond_c = COND_NCARRY;
          default: cond_c = COND_ALWAYS;
        endcase
      end
      OP_BL, OP_JR: begin
        cls_c     = (op == OP_BL) ? CLS_LINK : CLS_JR;
        alu_op_c  = ALUOP_PASS;
        alu_sel_c = ALUSEL_ZERO;
      end
      OP_HALT: cls_c = CLS_HALT;
      default: cls_c = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/kgp_control_sequencer.sv
// KGPMini multi-cycle control sequencer and program counter.
// Strobes are Moore outputs of state + latched opcode; reset masks them immediately.
module kgp_control_sequencer
  import kgp_isa_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FLAG_W-1:0]   flags,
  input  logic [XLEN-1:0]     imm_ext,
  input  logic [XLEN-1:0]     alu_result,
  output logic [XLEN-1:0]     PCout,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                DataPCSel,
  output logic                RegSelect,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [ALUSEL_W-1:0] ALUinSel,
  output logic                halted
);

  state_e               state_q, state_d;
  logic [OP_W-1:0]      op_q;
  logic [XLEN-1:0]      pc_q, pc_d, pc_seq, pc_rel;
  instr_class_e         cls_c;
  logic [ALUOP_W-1:0]   alu_op_c;
  logic [ALUSEL_W-1:0]  alu_sel_c;
  cond_e                cond_c;

  kgp_main_decoder u_dec (
    .op        (op_q),
    .cls_c     (cls_c),
    .alu_op_c  (alu_op_c),
    .alu_sel_c (alu_sel_c),
    .cond_c    (cond_c)
  );

  assign pc_seq = pc_q + XLEN'(1);
  assign pc_rel = pc_seq + imm_ext;
  assign PCout  = pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == ST_DECODE) op_q <= opcode;
    end
  end

  // Next state, PC update at the last state of each instruction, and strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    DataPCSel = 1'b0;
    RegSelect = 1'b0;
    ALUop     = ALUOP_FUNCT;
    ALUinSel  = ALUSEL_RT;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        ALUop    = alu_op_c;
        ALUinSel = alu_sel_c;
        case (cls_c)
          CLS_ALU, CLS_LINK:   state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            state_d = ST_FETCH;
            pc_d    = cond_met(cond_c, flags) ? pc_rel : pc_seq;
          end
          CLS_JR: begin
            state_d = ST_FETCH;
            pc_d    = alu_result;
          end
          CLS_HALT: state_d = ST_HALT;
          default: begin
            state_d = ST_FETCH;
            pc_d    = pc_seq;
          end
        endcase
      end
      ST_MEM: begin
        ALUop    = alu_op_c;
        ALUinSel = alu_sel_c;
        if (cls_c == CLS_LOAD) begin
          MemRead = 1'b1;
          state_d = ST_WB;
        end else begin
          MemWrite = 1'b1;
          state_d  = ST_FETCH;
          pc_d     = pc_seq;
        end
      end
      ST_WB: begin
        ALUop    = alu_op_c;
        ALUinSel = alu_sel_c;
        RegWrite = 1'b1;
        state_d  = ST_FETCH;
        if (cls_c == CLS_LINK) begin
          RegSelect = 1'b1;
          DataPCSel = 1'b1;
          pc_d      = pc_rel;
        end else begin
          MemtoReg = (cls_c == CLS_ALU);
          pc_d     = pc_seq;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
    // Reset dominates every output in the cycle it is asserted.
    if (reset) begin
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemtoReg  = 1'b0;
      DataPCSel = 1'b0;
      RegSelect = 1'b0;
      ALUop     = ALUOP_FUNCT;
      ALUinSel  = ALUSEL_RT;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_kgp_control_sequencer.sv
// Self-checking bench for kgp_control_sequencer: directed vector table,
// hand-written HALT/reset sequences, and random instructions vs a reference model.
module tb_kgp_control_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [2:0]  flags;
  logic [31:0] imm_ext, alu_result, PCout;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, halted;
  logic [2:0]  ALUop;
  logic [1:0]  ALUinSel;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] pc_model;

  kgp_control_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .flags      (flags),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .PCout      (PCout),
    .RegWrite   (RegWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .DataPCSel  (DataPCSel),
    .RegSelect  (RegSelect),
    .ALUop      (ALUop),
    .ALUinSel   (ALUinSel),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [2:0]  fl;
    int          cyc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl [21];

  function automatic logic [11:0] outs();
    return {RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect, ALUop, ALUinSel, halted};
  endfunction

  // Instruction latency in cycles, FETCH included.
  function automatic int ref_latency(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h04, 6'h09: return 4;
      6'h03:                             return 5;
      default:                           return 3;
    endcase
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [5:0] op, input logic [31:0] pc,
                                              input logic [31:0] imm, input logic [31:0] alu,
                                              input logic [2:0] fl);
    logic taken;
    taken = 1'b0;
    case (op)
      6'h05, 6'h09: taken = 1'b1;
      6'h06: taken = fl[2];
      6'h07: taken = fl[1];
      6'h08: taken = !fl[1];
      6'h0A: taken = fl[0];
      6'h0B: taken = !fl[0];
      6'h0C: return alu;
      6'h3F: return pc;
      default: taken = 1'b0;
    endcase
    return taken ? pc + 32'd1 + imm : pc + 32'd1;
  endfunction

  // Expected {RegWrite,MemRead,MemWrite,MemtoReg,DataPCSel,RegSelect,ALUop,ALUinSel,halted} at cycle c.
  function automatic logic [11:0] ref_outputs(input logic [5:0] op, input int c);
    logic rw, mr, mw, m2r, dps, rs;
    logic [2:0] aop;
    logic [1:0] asel;
    {rw, mr, mw, m2r, dps, rs} = 6'b0;
    aop = 3'd0;
    asel = 2'd0;
    if (c >= 3) begin
      case (op)
        6'h01, 6'h03, 6'h04: begin aop = 3'd1; asel = 2'd2; end
        6'h02:               begin aop = 3'd2; asel = 2'd2; end
        6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C: begin aop = 3'd3; asel = 2'd1; end
        default: ;
      endcase
    end
    case (op)
      6'h00, 6'h01, 6'h02: if (c == 4) begin rw = 1'b1; m2r = 1'b1; end
      6'h03: begin if (c == 4) mr = 1'b1; if (c == 5) rw = 1'b1; end
      6'h04: if (c == 4) mw = 1'b1;
      6'h09: if (c == 4) begin rw = 1'b1; dps = 1'b1; rs = 1'b1; end
      default: ;
    endcase
    return {rw, mr, mw, m2r, dps, rs, aop, asel, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Runs cyc cycles of one instruction; opcode valid only in DECODE, flags only in EXEC.
  task automatic run_instr(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] alu,
                           input logic [2:0] fl, input int cyc, input logic [31:0] exp_pc,
                           input string tag);
    for (int c = 1; c <= cyc; c++) begin
      opcode     = (c == 2) ? op : 6'($urandom);
      flags      = (c == 3) ? fl : 3'($urandom);
      alu_result = (c == 3) ? alu : $urandom;
      imm_ext    = imm;
      @(negedge clk);
      check({tag, " strobes"}, 32'(outs()), 32'(ref_outputs(op, c)));
      check({tag, " pc"}, PCout, pc_model);
      @(posedge clk);
      #1;
    end
    pc_model = exp_pc;
  endtask

  initial begin
    tbl[0]  = '{6'h00, 32'd0,        32'd0,        3'b000, 4, 32'd1};
    tbl[1]  = '{6'h0C, 32'd0,        32'd5,        3'b000, 3, 32'd5};
    tbl[2]  = '{6'h03, 32'd7,        32'd0,        3'b000, 5, 32'd6};
    tbl[3]  = '{6'h0C, 32'd0,        32'd10,       3'b000, 3, 32'd10};
    tbl[4]  = '{6'h07, 32'hFFFFFFFC, 32'd0,        3'b010, 3, 32'd7};
    tbl[5]  = '{6'h0C, 32'd0,        32'd10,       3'b000, 3, 32'd10};
    tbl[6]  = '{6'h07, 32'hFFFFFFFC, 32'd0,        3'b101, 3, 32'd11};
    tbl[7]  = '{6'h0C, 32'd0,        32'd20,       3'b000, 3, 32'd20};
    tbl[8]  = '{6'h09, 32'd3,        32'd0,        3'b000, 4, 32'd24};
    tbl[9]  = '{6'h0C, 32'd0,        32'h40,       3'b000, 3, 32'h40};
    tbl[10] = '{6'h0C, 32'd0,        32'hFFFFFFFF, 3'b000, 3, 32'hFFFFFFFF};
    tbl[11] = '{6'h05, 32'd0,        32'd0,        3'b000, 3, 32'd0};
    tbl[12] = '{6'h01, 32'd9,        32'd0,        3'b000, 4, 32'd1};
    tbl[13] = '{6'h02, 32'd9,        32'd0,        3'b000, 4, 32'd2};
    tbl[14] = '{6'h04, 32'd9,        32'd0,        3'b000, 4, 32'd3};
    tbl[15] = '{6'h15, 32'd9,        32'd0,        3'b111, 3, 32'd4};
    tbl[16] = '{6'h06, 32'd10,       32'd0,        3'b100, 3, 32'd15};
    tbl[17] = '{6'h08, 32'd5,        32'd0,        3'b000, 3, 32'd21};
    tbl[18] = '{6'h0A, 32'd2,        32'd0,        3'b001, 3, 32'd24};
    tbl[19] = '{6'h0B, 32'd2,        32'd0,        3'b001, 3, 32'd25};
    tbl[20] = '{6'h06, 32'd100,      32'd0,        3'b011, 3, 32'd26};

    reset = 1'b1;
    opcode = 6'h00;
    flags = 3'b000;
    imm_ext = 32'd0;
    alu_result = 32'd0;
    pc_model = 32'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset strobes", 32'(outs()), 32'd0);
    check("reset pc", PCout, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].imm, tbl[i].alu, tbl[i].fl, tbl[i].cyc, tbl[i].exp_pc, "vec");

    // HALT: absorbing, PC frozen, only halted high.
    run_instr(6'h3F, 32'd1, 32'd0, 3'b000, 3, pc_model, "halt entry");
    for (int k = 0; k < 10; k++) begin
      opcode = 6'($urandom);
      flags = 3'($urandom);
      @(negedge clk);
      check("halt strobes", 32'(outs()), 32'h1);
      check("halt pc", PCout, 32'd26);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("halt reset masks halted", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_model = 32'd0;

    // Reset during MEM of a SW: MemWrite masked, back to FETCH at RESET_PC.
    run_instr(6'h01, 32'd4, 32'd0, 3'b000, 4, 32'd1, "pre-sw addi");
    run_instr(6'h04, 32'd4, 32'd0, 3'b000, 3, pc_model, "sw partial");
    reset = 1'b1;
    @(negedge clk);
    check("sw mem reset strobes", 32'(outs()), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_model = 32'd0;
    run_instr(6'h00, 32'd0, 32'd0, 3'b000, 4, 32'd1, "post-reset rtype");

    // Random instruction stream against the reference model.
    for (int n = 0; n < 80; n++) begin
      logic [5:0]  op;
      logic [31:0] imm, alu;
      logic [2:0]  fl;
      int sel;
      sel = int'($urandom_range(0, 13));
      op  = (sel == 13) ? 6'($urandom_range(13, 62)) : 6'(sel);
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(8'($urandom)));
      alu = $urandom;
      fl  = 3'($urandom);
      run_instr(op, imm, alu, fl, ref_latency(op), ref_next_pc(op, pc_model, imm, alu, fl), "rand");
    end
    @(negedge clk);
    check("final pc", PCout, pc_model);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
